// File: rtl/bus_mem_responder.sv
// Memory-side responder for the CPU external bus: decodes an address window,
// serves reads/writes from a word array and stretches accesses via the lock line.
module bus_mem_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'h8000,
  parameter int          ADDR_BITS   = 8,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rw,
  input  logic [15:0] i_addr,
  inout  wire  [15:0] io_data,
  inout  wire         io_lock,
  output logic        o_busy
);

  localparam int         DEPTH   = 1 << ADDR_BITS;
  localparam bit         NO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] WS_M1   = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [15:0]            r_cap_addr;
  logic                   r_cap_rw;
  logic [3:0]             r_cnt;
  logic [3:0]             w_cnt_nxt;
  logic                   r_busy;
  logic [15:0]            r_mem [0:DEPTH-1];

  logic                   w_sel;
  logic                   w_match;
  logic [ADDR_BITS-1:0]   w_index;
  logic                   w_capture;
  logic                   w_complete;
  logic                   w_lock;
  logic                   w_drive_data;
  logic                   w_drive_lock;

  assign w_sel   = (i_addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
  assign w_match = ({i_addr, i_rw} == {r_cap_addr, r_cap_rw});
  // While an access is live the bus pair equals the captured pair, so the
  // live address indexes the array (this also covers the zero-wait case).
  assign w_index = i_addr[ADDR_BITS-1:0];

  always_comb begin
    w_next     = r_state;
    w_cnt_nxt  = r_cnt;
    w_capture  = 1'b0;
    w_complete = 1'b0;
    w_lock     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sel) begin
          w_capture = 1'b1;
          if (NO_WAIT) begin
            w_complete = 1'b1;
            w_next     = S_HOLD;
          end else begin
            w_lock    = 1'b1;
            w_cnt_nxt = WS_M1;
            w_next    = S_WAIT;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        // A changed address phase abandons the access before anything else.
        if (!w_match) begin
          w_next = S_IDLE;
        end else if (r_cnt != 4'd0) begin
          w_lock    = 1'b1;
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_complete = 1'b1;
          w_next     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!w_match || !w_sel) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_HOLD;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_cap_addr <= 16'h0000;
      r_cap_rw   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_next != S_IDLE);
      if (w_capture) begin
        r_cap_addr <= i_addr;
        r_cap_rw   <= i_rw;
      end
    end
  end

  // Array is deliberately not reset; only a completed, unreset write lands.
  always_ff @(posedge clk) begin
    if (!rst && w_complete && i_rw) begin
      r_mem[w_index] <= io_data;
    end
  end

  assign w_drive_data = !rst && !i_rw &&
                        (w_complete || ((r_state == S_HOLD) && w_match));
  assign w_drive_lock = !rst && w_lock;

  assign io_data = w_drive_data ? r_mem[w_index] : 16'bz;
  assign io_lock = w_drive_lock ? 1'b1 : 1'bz;
  assign o_busy  = r_busy;

endmodule
